// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_pkg
//  Purpose  : Shared definitions for the bit-serial subtractor controller.
//             Holds the controller state encoding and the default operand
//             width.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    // Default operand/result width used by serial_sub_ctrl
    localparam int SERIAL_SUB_WIDTH_DEF = 8;

    // Controller state encoding
    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sub_bit_cell.sv
`default_nettype none
// ============================================================================
//  Module   : sub_bit_cell
//  Purpose  : One-bit full subtractor (ai - bi - bin), built from two
//             half-subtractor stages whose borrows are ORed together.
//  Ports    : ai   in  minuend bit
//             bi   in  subtrahend bit
//             bin  in  borrow in
//             d    out difference bit
//             bout out borrow out
//  Revision : 1.0 - initial release
// ============================================================================
module sub_bit_cell (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    // Stage 1: ai - bi
    assign w_d1 = ai ^ bi;
    assign w_b1 = ~ai & bi;

    // Stage 2: (ai - bi) - bin
    assign d    = w_d1 ^ bin;
    assign w_b2 = ~w_d1 & bin;

    // At most one stage can borrow, so OR gives the full borrow
    assign bout = w_b1 | w_b2;

endmodule
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_ctrl
//  Purpose  : Bit-serial unsigned subtractor. On start (in IDLE) a and b are
//             captured, then one bit per cycle is processed LSB first for
//             WIDTH cycles, after which the result is published and done
//             pulses for one cycle.
//  Ports    : clk        in  clock, rising edge
//             rst        in  synchronous active-high reset
//             start      in  request a subtraction (honoured in IDLE only)
//             a, b       in  minuend / subtrahend, sampled with start
//             busy       out high in RUN and DONE
//             done       out one-cycle pulse when a new result is valid
//             diff       out a - b modulo 2^WIDTH (held until next result)
//             borrow_out out 1 when a < b (unsigned)
//             zero       out 1 when diff == 0 (only with macro below)
//  Config   : SERIAL_SUB_ZERO_FLAG_EN - adds the zero output and register
//  Revision : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    // Counter holds 0..WIDTH so it never wraps during RUN
    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_diff;
    logic [WIDTH-1:0]   w_acc_next;
    logic               r_bin;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_d;
    logic               w_bout;
    logic               w_last;

    sub_bit_cell u_sub_bit_cell (
        .ai   (r_a[0]),
        .bi   (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last = (r_cnt == c_LAST_BIT);

    // Result bits enter at the MSB and shift down; after WIDTH steps the
    // first (LSB) result bit has reached position 0.
    always_comb begin
        w_acc_next            = r_acc >> 1;
        w_acc_next[WIDTH-1]   = w_d;
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_bin <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_bin <= w_bout;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    // Publish on the same edge that enters DONE
                    if (w_last) begin
                        r_diff   <= w_acc_next;
                        r_borrow <= w_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_zero <= (w_acc_next == '0);
        end
    end

    assign zero = r_zero;
`endif

endmodule
`default_nettype wire

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled with start.
REQ-006 b  input  WIDTH  subtrahend; sampled with start.
REQ-007 busy  output  1  high while an operation is in RUN or DONE.
REQ-008 done  output  1  one-cycle pulse marking a valid new result.
REQ-009 diff  output  WIDTH  result a-b, modulo 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow; 1 iff a < b (unsigned).
REQ-011 zero  output  1  present only with SERIAL_SUB_ZERO_FLAG_EN; 1 iff diff == 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL latch a and b into shift registers, clear the running borrow and bit counter, and enter RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 RUN SHALL process one bit per cycle, LSB first: d = ai^bi^bin; bout = (~ai&bi) | (~(ai^bi)&bin).
REQ-016 RUN SHALL last exactly WIDTH cycles, then enter DONE.
REQ-017 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap during RUN.
REQ-018 On entry to DONE, the assembled difference and final borrow SHALL be copied into diff and borrow_out in the same edge.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 done SHALL rise exactly WIDTH+1 cycles after the edge at which start was sampled.
REQ-021 diff and borrow_out SHALL hold the last result, unchanged during RUN, until the next DONE entry.
REQ-022 start in RUN or DONE SHALL be ignored; a, b and the in-flight result SHALL be unaffected.
REQ-023 start held high continuously SHALL launch a new operation on every IDLE cycle, one per WIDTH+2 cycles.
REQ-024 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-025 WIDTH=1 SHALL reduce to a sequenced half subtractor: RUN is 1 cycle and bin is always 0.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and set diff, borrow_out, busy, done and zero (if present) to 0.
REQ-027 rst asserted mid-RUN or in DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-028 rst has priority over start when both are high at the same edge.

Configuration
REQ-029 With SERIAL_SUB_ZERO_FLAG_EN defined, the zero port and its register SHALL exist; zero updates together with diff.
REQ-030 Without SERIAL_SUB_ZERO_FLAG_EN, neither the zero port nor its logic SHALL exist; all other behaviour is identical.

Structure
REQ-031 Package serial_sub_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and the default-width constant SERIAL_SUB_WIDTH_DEF=8.
REQ-032 The per-bit arithmetic SHALL live in sub-module sub_bit_cell: a one-bit full subtractor built from two half-subtractor stages plus an OR of their borrows.
REQ-033 serial_sub_ctrl SHALL instantiate exactly one sub_bit_cell.

Verification
REQ-034 rst=1 for 2 cycles -> diff=0, borrow_out=0, busy=0, done=0, zero=0.
REQ-035 WIDTH=8, a=8'h05, b=8'h03, start pulse -> done at start+9, diff=8'h02, borrow_out=0.
REQ-036 WIDTH=8, a=8'h03, b=8'h05 -> diff=8'hFE, borrow_out=1; with macro, zero=0.
REQ-037 WIDTH=8, a=b=8'hAA -> diff=8'h00, borrow_out=0; with macro, zero=1.
REQ-038 WIDTH=8, start with a=8'h10, b=8'h01; restart with a=8'hFF in RUN cycle 3 -> ignored, diff=8'h0F. Second run: rst in RUN cycle 4 -> IDLE next cycle, outputs 0, no done.
REQ-039 WIDTH=1, all four (a,b) pairs -> (diff,borrow_out) = 00:(0,0), 01:(1,1), 10:(1,0), 11:(0,0); each done at start+2.
